// File: rtl/conv_requant_pkg.sv
// Shared widths and requantization arithmetic for conv_requant and its bench.
// The round/shift/saturate helper is the single definition of the output math.
package conv_pkg;

   localparam int O_CONV_BW = 20;
   localparam int I_BW      = 8;
   localparam int B_BW      = 16;
   localparam int SHIFT_BW  = 5;
   localparam int CNT_BW    = 16;

   // Bias sum cannot overflow at this width.
   localparam int SUM_W = ((O_CONV_BW > B_BW) ? O_CONV_BW : B_BW) + 2;
   // Headroom so the rounding constant never overflows, even at the largest shift.
   localparam int EXT_W = SUM_W + (1 << SHIFT_BW);

   typedef struct packed {
      logic signed [I_BW-1:0] data;
      logic                   sat;
   } rq_res_t;

   function automatic rq_res_t round_shift_sat(
      input logic signed [SUM_W-1:0]    value,
      input logic        [SHIFT_BW-1:0] shift,
      input logic                       relu_en
   );
      logic signed [EXT_W-1:0] r;
      logic signed [EXT_W-1:0] half;
      logic signed [EXT_W-1:0] q;
      rq_res_t                 res;
      r    = (relu_en && value[SUM_W-1]) ? '0 : {{(EXT_W-SUM_W){value[SUM_W-1]}}, value};
      half = EXT_W'(1) << (shift - 1'b1);
      q    = (shift == '0) ? r : ((r + half) >>> shift);
      res.sat = 1'b1;
      // Out of range whenever the bits above the result sign are not a pure sign extension.
      if (!q[EXT_W-1] && (q[EXT_W-2:I_BW-1] != '0)) begin
         res.data = {1'b0, {(I_BW-1){1'b1}}};
      end else if (q[EXT_W-1] && (q[EXT_W-2:I_BW-1] != '1)) begin
         res.data = {1'b1, {(I_BW-1){1'b0}}};
      end else begin
         res.data = q[I_BW-1:0];
         res.sat  = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/conv_requant_if.sv
// Stream bundle between the MAC chain, conv_requant and the feature-map write buffer.
// slave = requant block side, master = producer/consumer side.
interface conv_requant_if;
   import conv_pkg::*;

   logic                         i_valid;
   logic                         i_ready;
   logic signed [O_CONV_BW-1:0]  i_data;
   logic signed [B_BW-1:0]       i_bias;
   logic        [SHIFT_BW-1:0]   i_shift;
   logic                         i_relu_en;
   logic                         o_valid;
   logic                         o_ready;
   logic signed [I_BW-1:0]       o_data;
   logic        [CNT_BW-1:0]     o_sat_cnt;

   modport slave (
      input  i_valid, i_data, i_bias, i_shift, i_relu_en, o_ready,
      output i_ready, o_valid, o_data, o_sat_cnt
   );

   modport master (
      output i_valid, i_data, i_bias, i_shift, i_relu_en, o_ready,
      input  i_ready, o_valid, o_data, o_sat_cnt
   );

endinterface

// File: rtl/conv_requant.sv
// Bias add, optional ReLU, rounding right shift and saturation in a 2-slot valid/ready pipe.
// CONV_REQUANT_SATCNT_EN enables the saturation event counter on o_sat_cnt.
module conv_requant
   import conv_pkg::*;
(
   input  logic            clk,
   input  logic            global_rst_n,
   input  logic            rst,
   conv_requant_if.slave   bus
);

   logic                    r_s1_valid;
   logic signed [SUM_W-1:0] r_s1_sum;
   logic                    r_s2_valid;
   logic signed [I_BW-1:0]  r_s2_data;
   logic                    r_s2_sat;

   logic                    w_s2_load;
   logic                    w_s1_load;
   rq_res_t                 w_rq;

   assign w_s2_load   = !r_s2_valid || bus.o_ready;
   assign w_s1_load   = !r_s1_valid || w_s2_load;
   assign bus.i_ready = !rst && w_s1_load;

   assign w_rq = round_shift_sat(r_s1_sum, bus.i_shift, bus.i_relu_en);

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sum   <= '0;
      end else if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sum   <= '0;
      end else if (w_s1_load) begin
         r_s1_valid <= bus.i_valid;
         if (bus.i_valid) begin
            r_s1_sum <= {{(SUM_W-O_CONV_BW){bus.i_data[O_CONV_BW-1]}}, bus.i_data}
                      + {{(SUM_W-B_BW){bus.i_bias[B_BW-1]}}, bus.i_bias};
         end
      end
   end

   // Output register only changes on a load carrying real data, so a stalled word holds.
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_sat   <= 1'b0;
      end else if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_sat   <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data <= w_rq.data;
            r_s2_sat  <= w_rq.sat;
         end
      end
   end

   assign bus.o_valid = r_s2_valid;
   assign bus.o_data  = r_s2_data;

`ifdef CONV_REQUANT_SATCNT_EN
   logic [CNT_BW-1:0] r_sat_cnt;

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         r_sat_cnt <= '0;
      end else if (rst) begin
         r_sat_cnt <= '0;
      end else if (r_s2_valid && bus.o_ready && r_s2_sat && (r_sat_cnt != '1)) begin
         r_sat_cnt <= r_sat_cnt + 1'b1;
      end
   end

   assign bus.o_sat_cnt = r_sat_cnt;
`else
   // Flag is still consumed so both builds share the identical stage-2 datapath.
   assign bus.o_sat_cnt = {CNT_BW{r_s2_sat & 1'b0}};
`endif

endmodule
